// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage pipeline.
//
// Sits downstream of the EXE/MEM register. It drives a single-port data-memory
// bus with a req/ready handshake and freezes the upstream pipeline while the
// memory inserts wait states. It also resolves conditional branches, forwards
// the load in WB to a dependent store, and holds the MEM/WB register.
//
// Ports
//   clk, clr                 clock (rising edge), async active-high reset
//   mwreg, mm2reg, mwmem, mz regfile write, load, store, ALU zero (EXE/MEM)
//   maluout, mdest           ALU result / address, destination register
//   datain, mldst_depen      store data, store-data-from-WB-load select
//   mbpc, mbeq, mbne         branch target and branch kinds
//   dmem_rdata, dmem_ready   memory read data and completion
//   dmem_req/we/addr/wdata   memory request bus
//   mem_stall                freeze PC, IF/ID, ID/EXE, EXE/MEM
//   branch_taken/target      fetch redirect
//   wwreg, wm2reg, wmo,
//   walu, wdest              MEM/WB register outputs
//   stall_cnt                saturating stall-cycle counter
module mem_stage (
  input  logic        clk,
  input  logic        clr,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic        mz,
  input  logic [31:0] maluout,
  input  logic [4:0]  mdest,
  input  logic [31:0] datain,
  input  logic        mldst_depen,
  input  logic [31:0] mbpc,
  input  logic        mbeq,
  input  logic        mbne,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        mem_stall,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wdest,
  output logic [15:0] stall_cnt
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state;
  logic                access;
  logic [DATA_W-1:0]   wdata_sel;
  logic [DATA_W-1:0]   addr_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic                we_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign access        = mm2reg | mwmem;
  // wmo is the WB-stage load; it stays put while stalled, and the holding
  // register keeps the bus stable regardless.
  assign wdata_sel     = mldst_depen ? wmo : datain;
  assign mem_stall     = access & ~dmem_ready;
  assign branch_taken  = (mbeq & mz) | (mbne & ~mz);
  assign branch_target = mbpc;

  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = mwmem;
    dmem_addr  = maluout;
    dmem_wdata = wdata_sel;
    if (state == S_WAIT) begin
      dmem_req   = ~clr;
      dmem_we    = we_p1;
      dmem_addr  = addr_p1;
      dmem_wdata = wdata_p1;
    end else begin
      dmem_req   = access & ~clr;
    end
  end

  // Stage boundary: bus FSM and access holding registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_IDLE;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      we_p1    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            addr_p1  <= maluout;
            wdata_p1 <= wdata_sel;
            we_p1    <= mwmem;
            if (!dmem_ready) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage boundary: MEM/WB register; a stall inserts a bubble
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wmo    <= '0;
      walu   <= '0;
      wdest  <= '0;
    end else if (mem_stall) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
    end else begin
      wwreg  <= mwreg;
      wm2reg <= mm2reg;
      walu   <= maluout;
      wdest  <= mdest;
      if (mm2reg) wmo <= dmem_rdata;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cnt <= '0;
    end else if (mem_stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the EXE/MEM pipeline register. Consumes that register's outputs. Drives a single-port data-memory bus with a req/ready handshake and stalls the pipeline on wait states. Also resolves conditional branches, forwards load data to a dependent store, and contains the MEM/WB pipeline register.

## Interface

Parameters:
- none

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `clr`  in  1  reset, asynchronous, active-high
- `mwreg`, `mm2reg`, `mwmem`, `mz`  in  1 each  regfile write, load, store, ALU zero flag from EXE/MEM
- `maluout`  in  32  ALU result / memory address
- `mdest`  in  5  destination register
- `datain`  in  32  store data
- `mldst_depen`  in  1  store data comes from the load currently in WB
- `mbpc`  in  32  branch target
- `mbeq`, `mbne`  in  1 each  branch-if-equal / branch-if-not-equal
- `dmem_rdata`  in  32  read data, valid when `dmem_ready`=1
- `dmem_ready`  in  1  access completes this cycle
- `dmem_req`  out  1  access request
- `dmem_we`  out  1  write enable
- `dmem_addr`  out  32  word address
- `dmem_wdata`  out  32  write data
- `mem_stall`  out  1  freeze PC, IF/ID, ID/EXE and EXE/MEM registers
- `branch_taken`  out  1  redirect fetch, flush younger instructions
- `branch_target`  out  32  redirect PC
- `wwreg`, `wm2reg`  out  1 each  registered to WB
- `wmo`  out  32  registered load data
- `walu`  out  32  registered ALU result
- `wdest`  out  5  registered destination
- `stall_cnt`  out  16  count of stall cycles, saturating

## Operation

- Access = `mm2reg | mwmem`. Decode guarantees that an access and a branch never occur in the same instruction. `mm2reg` and `mwmem` are never both 1.
- Store data selection: `dmem_wdata` = `wmo` if `mldst_depen`, else `datain`.
- Address and write data are captured into internal holding registers on the first cycle of an access. They are driven from those registers in WAIT. The bus stays stable even though `wmo` is the forwarding source.
- FSM, two states:
  - IDLE:
    - `dmem_req` = access.
    - `dmem_addr` = `maluout`.
    - `dmem_we` = `mwmem`.
    - If access and `dmem_ready`=1, the access completes with zero wait and the FSM stays in IDLE.
    - If access and `dmem_ready`=0, go to WAIT.
  - WAIT:
    - `dmem_req`=1 from the holding registers.
    - If `dmem_ready`=1, go to IDLE. Completion occurs in this cycle.
- `mem_stall` = access & ~`dmem_ready` (combinational) in both states.
- Branch resolution:
  - `branch_taken` = (`mbeq` & `mz`) | (`mbne` & ~`mz`), combinational.
  - `branch_target` = `mbpc`.
  - There is no stall interaction.
- MEM/WB register, when not stalled, loads:
  - `wwreg`←`mwreg`, `wm2reg`←`mm2reg`, `walu`←`maluout`, `wdest`←`mdest`
  - `wmo`←`dmem_rdata` if load, else holds
- MEM/WB register, when stalled: `wwreg`←0 and `wm2reg`←0 (bubble). `wmo`, `walu`, `wdest` hold.
- `stall_cnt` increments on each cycle with `mem_stall`=1 and saturates at 0xFFFF. Only `clr` clears it.

## Timing

- Reset (`clr`=1, asynchronous): FSM to IDLE. `wwreg`, `wm2reg`, `wmo`, `walu`, `wdest`, `stall_cnt`, and the holding registers all go to 0.
- With `clr` asserted, the combinational outputs follow the current inputs, and `dmem_req` is forced to 0.
- Reset mid-WAIT abandons the access. No WB write results.
- Zero-wait access:
  - The request and `dmem_ready` are in the same cycle.
  - No stall.
  - WB sees the result one clock later.
- N-wait access: `mem_stall` is high for exactly N cycles. WB sees the result on the clock after `dmem_ready`.
- Back-to-back accesses:
  - A new access can issue in the cycle after completion.
  - No idle cycle is required.
- `dmem_ready` outside of a request is ignored.
- `branch_taken` is valid in the same cycle the branch occupies MEM. The upstream flush takes effect at the next edge.

## Test plan

- Reset mid-WAIT: store to 0x10, ready held 0, `clr` pulsed on cycle 2 → `dmem_req`=0 immediately, all W outputs 0, `stall_cnt`=0, FSM back in IDLE.
- Zero-wait load: `maluout`=0x40, `mm2reg`=1, ready=1, rdata=0xDEADBEEF → no stall, next cycle `wmo`=0xDEADBEEF, `wwreg`=1, `wm2reg`=1.
- 3-wait store: `datain`=0x1234, addr 0x80, ready high on 4th cycle → `mem_stall`=1 for 3 cycles, addr/wdata constant, W bubbles (`wwreg`=0) during the stall, `stall_cnt`=3.
- Load→store forwarding: load returns 0xA5A5A5A5, next instruction is a store with `mldst_depen`=1 and `datain`=0 → `dmem_wdata`=0xA5A5A5A5.
- Branches:
  - `mbeq`=1, `mz`=1, `mbpc`=0x200 → `branch_taken`=1, `branch_target`=0x200.
  - `mbne`=1, `mz`=1 → `branch_taken`=0.
- Counter saturation: preload via 65 540 stall cycles → `stall_cnt` holds at 0xFFFF.
